char_drain_tx: RTL and testbench

CHAR_DRAIN_TX -- requirements
Module: char_drain_tx

---
 rtl/char_drain_tx_pkg.sv | 21 ++
 rtl/char_drain_tx_baud_tick.sv | 31 +++
 rtl/char_drain_tx.sv | 90 +++++++++
 tb/tb_char_drain_tx.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/char_drain_tx_pkg.sv
// Shared definitions for the UART character drain: FSM state encodings and
// the default bit period for a 115200 baud line on a 100 MHz clock.
package char_drain_tx_pkg;

    localparam int DEF_CLKS_PER_BIT = 868;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_READ  = 3'd1;
    localparam state_t S_LOAD  = 3'd2;
    localparam state_t S_START = 3'd3;
    localparam state_t S_DATA  = 3'd4;
    localparam state_t S_STOP  = 3'd5;

    // States in which the serial line is driving a timed bit period.
    function automatic logic is_bit_state(input state_t s);
        return (s == S_START) || (s == S_DATA) || (s == S_STOP);
    endfunction

endpackage

// File: rtl/char_drain_tx_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses tick_o on the last
// count, restarting from zero on the following cycle.
module baud_tick
    import char_drain_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int CTR_WID      = 10
) (
    input  logic clk_i,
    input  logic nrst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [CTR_WID-1:0] LAST = CTR_WID'(CLKS_PER_BIT - 1);

    logic [CTR_WID-1:0] cnt;

    assign tick_o = (cnt == LAST);

    // NOTE: sequential state is written with <= only, so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk_i) begin
        if (!nrst_i || clr_i || tick_o) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CTR_WID'(1);
        end
    end

endmodule

// File: rtl/char_drain_tx.sv
// UART transmitter that drains an external character FIFO: one read strobe per
// character, then start bit, DATA_WID data bits LSB first and a stop bit.
module char_drain_tx
    import char_drain_tx_pkg::*;
#(
    parameter int DATA_WID     = 8,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int CTR_WID      = 10
) (
    input  logic                clk_i,
    input  logic                nrst_i,
    input  logic                en_i,
    input  logic                fifo_empty_i,
    input  logic [DATA_WID-1:0] fifo_data_i,
    output logic                fifo_rd_o,
    output logic                tx_o,
    output logic                busy_o,
    output logic [7:0]          dbg_tx_count
);

    localparam int IDX_WID = (DATA_WID > 1) ? $clog2(DATA_WID) : 1;
    localparam logic [IDX_WID-1:0] LAST_IDX = IDX_WID'(DATA_WID - 1);

    state_t              state;
    state_t              state_nxt;
    logic [DATA_WID-1:0] shreg;
    logic [IDX_WID-1:0]  bit_idx;
    logic                tick;

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CTR_WID     (CTR_WID)
    ) u_baud_tick (
        .clk_i (clk_i),
        .nrst_i(nrst_i),
        .clr_i (!is_bit_state(state)),
        .tick_o(tick)
    );

    assign busy_o = (state != S_IDLE);

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            S_IDLE:  if (en_i && !fifo_empty_i) state_nxt = S_READ;
            S_READ:  state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_START;
            S_START: if (tick) state_nxt = S_DATA;
            S_DATA:  if (tick && (bit_idx == LAST_IDX)) state_nxt = S_STOP;
            S_STOP:  if (tick) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state        <= S_IDLE;
            tx_o         <= 1'b1;
            fifo_rd_o    <= 1'b0;
            dbg_tx_count <= '0;
            shreg        <= '0;
            bit_idx      <= '0;
        end else begin
            state     <= state_nxt;
            // S_READ is only ever entered from S_IDLE, giving one strobe per character.
            fifo_rd_o <= (state_nxt == S_READ);

            // The line follows the current state, one cycle behind it.
            case (state)
                S_START: tx_o <= 1'b0;
                S_DATA:  tx_o <= shreg[0];
                default: tx_o <= 1'b1;
            endcase

            if (state == S_LOAD) begin
                shreg   <= fifo_data_i;
                bit_idx <= '0;
            end else if ((state == S_DATA) && tick) begin
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + IDX_WID'(1);
            end

            if ((state == S_STOP) && tick) begin
                dbg_tx_count <= dbg_tx_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_char_drain_tx.sv
// Self-checking bench for char_drain_tx: a queue-based FIFO model feeds the DUT
// and expected line waveforms are built from the UART framing rules.
module tb_char_drain_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       nrst_i = 1'b0;
    logic       en_i = 1'b0;
    logic       fifo_empty_i = 1'b1;
    logic [7:0] fifo_data_i = 8'h00;
    logic       fifo_rd_o;
    logic       tx_o;
    logic       busy_o;
    logic [7:0] dbg_tx_count;

    // Second instance for the counter-wrap run with a short bit period.
    logic       en_w = 1'b0;
    logic       fifo_empty_w = 1'b0;
    logic [7:0] fifo_data_w = 8'h5A;
    logic       rd_w;
    logic       tx_w;
    logic       busy_w;
    logic [7:0] cnt_w;

    always #5 clk = ~clk;

    char_drain_tx #(.DATA_WID(8), .CLKS_PER_BIT(CPB), .CTR_WID(10)) dut (
        .clk_i       (clk),
        .nrst_i      (nrst_i),
        .en_i        (en_i),
        .fifo_empty_i(fifo_empty_i),
        .fifo_data_i (fifo_data_i),
        .fifo_rd_o   (fifo_rd_o),
        .tx_o        (tx_o),
        .busy_o      (busy_o),
        .dbg_tx_count(dbg_tx_count)
    );

    char_drain_tx #(.DATA_WID(8), .CLKS_PER_BIT(2), .CTR_WID(10)) dut_w (
        .clk_i       (clk),
        .nrst_i      (nrst_i),
        .en_i        (en_w),
        .fifo_empty_i(fifo_empty_w),
        .fifo_data_i (fifo_data_w),
        .fifo_rd_o   (rd_w),
        .tx_o        (tx_w),
        .busy_o      (busy_w),
        .dbg_tx_count(cnt_w)
    );

    typedef struct {
        logic [7:0] data;
        bit         en;
        bit         push;
        int         exp_rd;
        logic [0:9] exp_bits;
        int         exp_inc;
    } vec_t;

    vec_t       vecs[7];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] sent_q[$];
    bit         exp_q[$];
    logic       prev_rd = 1'b0;
    int         rd_count = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: FIFO pops on a sampled read strobe, data shows up the next cycle.
    task automatic step();
        @(posedge clk);
        #1;
        if (prev_rd && fifo_q.size() > 0) fifo_data_i = fifo_q.pop_front();
        else fifo_data_i = 8'($urandom);
        fifo_empty_i = (fifo_q.size() == 0);
        prev_rd = fifo_rd_o;
        if (fifo_rd_o) rd_count++;
    endtask

    task automatic push(input logic [7:0] c);
        fifo_q.push_back(c);
        sent_q.push_back(c);
        fifo_empty_i = 1'b0;
    endtask

    task automatic flush();
        fifo_q.delete();
        sent_q.delete();
        fifo_empty_i = 1'b1;
    endtask

    task automatic do_reset();
        nrst_i = 1'b0;
        en_i   = 1'b0;
        en_w   = 1'b0;
        flush();
        step();
        step();
        nrst_i  = 1'b1;
        prev_rd = 1'b0;
    endtask

    // Expected line samples from the first start-bit cycle: each frame is
    // start, 8 data bits LSB first, stop, each CPB cycles; frames 3 cycles apart.
    function automatic void build_model(input logic [7:0] chars[$]);
        exp_q.delete();
        foreach (chars[c]) begin
            if (c > 0) repeat (3) exp_q.push_back(1'b1);
            for (int b = 0; b < 10; b++) begin
                bit v;
                if (b == 0) v = 1'b0;
                else if (b == 9) v = 1'b1;
                else v = chars[c][b-1];
                repeat (CPB) exp_q.push_back(v);
            end
        end
    endfunction

    task automatic wait_fall(input string name, input int budget, output int waited);
        waited = 0;
        while (tx_o !== 1'b0 && waited < budget) begin
            step();
            waited++;
        end
        check({name, "_fall"}, int'(tx_o), 0);
    endtask

    task automatic compare_frames(input string name, input int budget, input int drop_at,
                                  output int waited);
        int mism;
        wait_fall(name, budget, waited);
        mism = 0;
        if (tx_o === 1'b0) begin
            foreach (exp_q[i]) begin
                if (i > 0) step();
                if (i == drop_at) en_i = 1'b0;
                if (tx_o !== exp_q[i]) mism++;
            end
        end else begin
            mism = exp_q.size();
        end
        check({name, "_wave"}, mism, 0);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int         w;
        int         base_rd;
        int         first_rd;
        int         mism;
        int         found;
        int         frames;
        int         exp_total;
        logic [7:0] base_cnt;
        logic [7:0] delta;
        logic [7:0] cq[$];
        bit         exp_tx;
        logic       prev_b;

        vecs[0] = '{8'h41, 1'b1, 1'b1, 1, 10'b0100000101, 1};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1, 10'b0000000001, 1};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1, 10'b0111111111, 1};
        vecs[3] = '{8'hA5, 1'b1, 1'b1, 1, 10'b0101001011, 1};
        vecs[4] = '{8'h80, 1'b1, 1'b1, 1, 10'b0000000011, 1};
        vecs[5] = '{8'h33, 1'b0, 1'b1, 0, 10'b1111111111, 0};
        vecs[6] = '{8'h00, 1'b1, 1'b0, 0, 10'b1111111111, 0};

        // Reset state
        do_reset();
        check("rst_tx", int'(tx_o), 1);
        check("rst_rd", int'(fifo_rd_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_count", int'(dbg_tx_count), 0);
        check("rst_tx_w", int'(tx_w), 1);

        // Single-character table
        foreach (vecs[r]) begin
            base_rd  = rd_count;
            base_cnt = dbg_tx_count;
            en_i     = vecs[r].en;
            if (vecs[r].push) push(vecs[r].data);
            first_rd = -1;
            mism     = 0;
            for (int k = 1; k <= FRAME + 8; k++) begin
                step();
                if (fifo_rd_o && first_rd < 0) first_rd = k;
                exp_tx = (vecs[r].exp_inc > 0 && k >= 4 && k < 4 + FRAME)
                         ? vecs[r].exp_bits[(k - 4) / CPB] : 1'b1;
                if (tx_o !== exp_tx) mism++;
            end
            check($sformatf("vec%0d_rd_pulses", r), rd_count - base_rd, vecs[r].exp_rd);
            check($sformatf("vec%0d_rd_cycle", r), first_rd, (vecs[r].exp_rd > 0) ? 1 : -1);
            check($sformatf("vec%0d_tx_wave", r), mism, 0);
            delta = dbg_tx_count - base_cnt;
            check($sformatf("vec%0d_count_inc", r), int'(delta), vecs[r].exp_inc);
            check($sformatf("vec%0d_busy_end", r), int'(busy_o), 0);
            en_i = 1'b0;
            flush();
        end

        // Empty FIFO with enable held high
        do_reset();
        en_i = 1'b1;
        mism = 0;
        found = 0;
        frames = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (fifo_rd_o) found++;
            if (tx_o !== 1'b1) mism++;
            if (busy_o) frames++;
        end
        check("empty_rd", found, 0);
        check("empty_tx_low", mism, 0);
        check("empty_busy", frames, 0);

        // Back-to-back frames 0x55, 0xAA
        do_reset();
        base_rd = rd_count;
        push(8'h55);
        push(8'hAA);
        en_i = 1'b1;
        build_model(sent_q);
        compare_frames("b2b", 10, -1, w);
        check("b2b_latency", w, 4);
        repeat (10) step();
        check("b2b_rd_pulses", rd_count - base_rd, 2);
        check("b2b_count", int'(dbg_tx_count), 2);
        check("b2b_busy_end", int'(busy_o), 0);

        // Enable dropped during data bit 3 with characters still queued
        do_reset();
        base_rd = rd_count;
        push(8'h3C);
        push(8'hC3);
        push(8'h0F);
        en_i = 1'b1;
        cq.delete();
        cq.push_back(8'h3C);
        build_model(cq);
        compare_frames("endrop_first", 10, 4 * CPB + 2, w);
        repeat (60) step();
        check("endrop_rd_pulses", rd_count - base_rd, 1);
        check("endrop_count", int'(dbg_tx_count), 1);
        check("endrop_idle_tx", int'(tx_o), 1);
        en_i = 1'b1;
        found = 0;
        for (int k = 0; k < 5 && found == 0; k++) begin
            step();
            if (fifo_rd_o) found = 1;
        end
        check("endrop_resume_rd", found, 1);
        cq.delete();
        cq.push_back(8'hC3);
        build_model(cq);
        compare_frames("endrop_second", 10, 0, w);
        repeat (60) step();
        check("endrop_count2", int'(dbg_tx_count), 2);
        check("endrop_fifo_left", fifo_q.size(), 1);

        // Reset pulse during data bit 5
        do_reset();
        push(8'h3C);
        push(8'h99);
        en_i = 1'b1;
        wait_fall("rstmid", 10, w);
        repeat (6 * CPB + 1) step();
        nrst_i = 1'b0;
        step();
        check("rstmid_tx", int'(tx_o), 1);
        check("rstmid_busy", int'(busy_o), 0);
        check("rstmid_count", int'(dbg_tx_count), 0);
        check("rstmid_rd", int'(fifo_rd_o), 0);
        nrst_i  = 1'b1;
        base_rd = rd_count;
        cq.delete();
        cq.push_back(8'h99);
        build_model(cq);
        compare_frames("rstmid_next", 10, -1, w);
        repeat (10) step();
        check("rstmid_next_rd", rd_count - base_rd, 1);
        check("rstmid_next_count", int'(dbg_tx_count), 1);

        // Randomized bursts against the framing model
        do_reset();
        exp_total = 0;
        for (int round = 0; round < 5; round++) begin
            int n;
            flush();
            base_rd = rd_count;
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) push(8'($urandom));
            en_i = 1'b1;
            build_model(sent_q);
            compare_frames($sformatf("rand%0d", round), 10, -1, w);
            check($sformatf("rand%0d_latency", round), w, 4);
            en_i = 1'b0;
            repeat (4 + $urandom_range(0, 7)) step();
            exp_total += n;
            check($sformatf("rand%0d_rd_pulses", round), rd_count - base_rd, n);
            check($sformatf("rand%0d_count", round), int'(dbg_tx_count), exp_total % 256);
            check($sformatf("rand%0d_busy_end", round), int'(busy_o), 0);
        end

        // Counter wrap over 256 frames (bit period of 2 cycles)
        do_reset();
        en_w   = 1'b1;
        frames = 0;
        prev_b = 1'b0;
        for (int c = 0; c < 7000 && frames < 256; c++) begin
            step();
            if (prev_b && !busy_w) begin
                frames++;
                if (frames == 255) check("wrap_255", int'(cnt_w), 255);
            end
            prev_b = busy_w;
        end
        en_w = 1'b0;
        check("wrap_frames", frames, 256);
        check("wrap_count", int'(cnt_w), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
